// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder: one BLK-bit lookahead block per stage, carry rippled via flops.
// Optional macro SUB_EN adds a 'sub' input that turns the operation into a - b.
module pipelined_cla_adder #(
    parameter int unsigned W   = 32,
    parameter int unsigned BLK = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
`ifdef SUB_EN
    input  logic         sub,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf,
    output logic         grp_p,
    output logic         grp_g
);

    localparam int unsigned NSTAGE = W / BLK;

    if (BLK < 1 || BLK > W || (W % BLK) != 0) begin : g_param_check
        $error("pipelined_cla_adder: W must be a non-zero multiple of BLK");
    end

    logic [NSTAGE-1:0]        valid_q, valid_d;
    logic [NSTAGE-1:0]        carry_q, carry_d;
    logic [NSTAGE-1:0]        pg_q, pg_d;
    logic [NSTAGE-1:0]        gg_q, gg_d;
    logic [NSTAGE-1:0][W-1:0] a_q, a_d;
    logic [NSTAGE-1:0][W-1:0] b_q, b_d;
    logic [NSTAGE-1:0][W-1:0] sum_q, sum_d;
    logic                     ovf_q, ovf_d;

    logic         adv;
    logic [W-1:0] b_eff;
    logic         cin_eff;

`ifdef SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub | cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    // Per-stage working signals, reused across the unrolled stage loop.
    logic [W-1:0]   a_in, b_in, s_in;
    logic           c0, pg_in, gg_in, v_in;
    logic [BLK-1:0] p, g;
    logic [BLK:0]   c;
    logic           prod, gen;
    int             km1;

    always_comb begin
        valid_d = '0;
        carry_d = '0;
        pg_d    = '0;
        gg_d    = '0;
        a_d     = '0;
        b_d     = '0;
        sum_d   = '0;
        ovf_d   = 1'b0;
        a_in    = '0;
        b_in    = '0;
        s_in    = '0;
        c0      = 1'b0;
        pg_in   = 1'b0;
        gg_in   = 1'b0;
        v_in    = 1'b0;
        p       = '0;
        g       = '0;
        c       = '0;
        prod    = 1'b0;
        gen     = 1'b0;
        km1     = 0;
        for (int k = 0; k < NSTAGE; k++) begin
            km1 = (k == 0) ? 0 : k - 1;
            if (k == 0) begin
                a_in  = a;
                b_in  = b_eff;
                s_in  = '0;
                c0    = cin_eff;
                pg_in = 1'b1;
                gg_in = 1'b0;
                v_in  = in_valid;
            end else begin
                a_in  = a_q[km1];
                b_in  = b_q[km1];
                s_in  = sum_q[km1];
                c0    = carry_q[km1];
                pg_in = pg_q[km1];
                gg_in = gg_q[km1];
                v_in  = valid_q[km1];
            end
            p    = a_in[k*BLK +: BLK] ^ b_in[k*BLK +: BLK];
            g    = a_in[k*BLK +: BLK] & b_in[k*BLK +: BLK];
            c    = '0;
            c[0] = c0;
            // Each carry is a flat sum of products over g/p and c0; no carry feeds another.
            for (int i = 0; i < BLK; i++) begin
                gen  = g[i];
                prod = p[i];
                for (int j = i - 1; j >= 0; j--) begin
                    gen  = gen | (prod & g[j]);
                    prod = prod & p[j];
                end
                c[i+1] = gen | (prod & c0);
            end
            // After the last iteration gen/prod hold the block generate/propagate.
            valid_d[k]               = v_in;
            a_d[k]                   = a_in;
            b_d[k]                   = b_in;
            sum_d[k]                 = s_in;
            sum_d[k][k*BLK +: BLK]   = p ^ c[BLK-1:0];
            carry_d[k]               = c[BLK];
            pg_d[k]                  = pg_in & prod;
            gg_d[k]                  = gen | (prod & gg_in);
            if (k == NSTAGE - 1) begin
                ovf_d = c[BLK] ^ c[BLK-1];
            end
        end
    end

    assign adv      = ~valid_q[NSTAGE-1] | out_ready;
    assign in_ready = adv;

    // Payload only loads with a valid beat, so outputs hold their last value across bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            carry_q <= '0;
            pg_q    <= '0;
            gg_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
        end else if (adv) begin
            valid_q <= valid_d;
            for (int k = 0; k < NSTAGE; k++) begin
                if (valid_d[k]) begin
                    carry_q[k] <= carry_d[k];
                    pg_q[k]    <= pg_d[k];
                    gg_q[k]    <= gg_d[k];
                    a_q[k]     <= a_d[k];
                    b_q[k]     <= b_d[k];
                    sum_q[k]   <= sum_d[k];
                end
            end
            if (valid_d[NSTAGE-1]) begin
                ovf_q <= ovf_d;
            end
        end
    end

    assign out_valid = valid_q[NSTAGE-1];
    assign sum       = sum_q[NSTAGE-1];
    assign cout      = carry_q[NSTAGE-1];
    assign ovf       = ovf_q;
    assign grp_p     = pg_q[NSTAGE-1];
    assign grp_g     = gg_q[NSTAGE-1];

endmodule
